// File: rtl/cyclic_shift_pkg.sv
// Shared constants, state encoding and rotate helper for the cyclic shift family.
package cyclic_shift_pkg;
  localparam int WIDTH   = 128;
  localparam int SHAMT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction
endpackage

// File: rtl/cyclic_right_shift_datapath.sv
// Working register and step counter; load takes priority, step rotates right by one.
module cyclic_right_shift_datapath
  import cyclic_shift_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   d_i,
  input  logic [SHAMT_W-1:0] amount_i,
  output logic [WIDTH-1:0]   q_o,
  output logic [SHAMT_W-1:0] remaining_o
);
  logic [WIDTH-1:0]   q_q, q_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;

  always_comb begin
    q_d   = q_q;
    rem_d = rem_q;
    if (load_i) begin
      q_d   = d_i;
      rem_d = amount_i;
    end else if (step_i && (rem_q != '0)) begin
      // The guard keeps the counter from wrapping even if step is mis-driven.
      q_d   = rotr1(q_q);
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(negedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      q_q   <= '0;
      rem_q <= '0;
    end else begin
      q_q   <= q_d;
      rem_q <= rem_d;
    end
  end

  assign q_o         = q_q;
  assign remaining_o = rem_q;
endmodule

// File: rtl/cyclic_right_shift_engine_128bit.sv
// Sequential right-rotate engine: start/busy/done handshake around a one-bit-per-edge datapath.
module cyclic_right_shift_engine_128bit
  import cyclic_shift_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               enable,
  input  logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   Q,
  output logic               busy,
  output logic               done,
  output logic [SHAMT_W-1:0] remaining,
  output state_t             dbg_state
);
  // Handshake: start is accepted only on an edge seen in IDLE; busy is high while
  // in SHIFT, done pulses for exactly one cycle in DONE; starts elsewhere are dropped.
  state_t state_q;
  logic   busy_q, done_q;
  logic   load, step;

  assign load = (state_q == ST_IDLE) && start;
  assign step = (state_q == ST_SHIFT) && enable;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (amount == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          if (enable && (remaining == SHAMT_W'(1))) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  cyclic_right_shift_datapath u_datapath (
    .clock_i     (clock),
    .reset_ni    (reset),
    .load_i      (load),
    .step_i      (step),
    .d_i         (D),
    .amount_i    (amount),
    .q_o         (Q),
    .remaining_o (remaining)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_cyclic_right_shift_engine_128bit.sv
// Self-checking bench for the right-rotate engine against an arithmetic rotate model.
module tb_cyclic_right_shift_engine_128bit;
  import cyclic_shift_pkg::*;

  logic               clock;
  logic               reset;
  logic               start;
  logic [SHAMT_W-1:0] amount;
  logic               enable;
  logic [WIDTH-1:0]   D;
  logic [WIDTH-1:0]   Q;
  logic               busy;
  logic               done;
  logic [SHAMT_W-1:0] remaining;
  state_t             dbg_state;

  int errors = 0;
  int checks = 0;

  cyclic_right_shift_engine_128bit dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .amount    (amount),
    .enable    (enable),
    .D         (D),
    .Q         (Q),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .dbg_state (dbg_state)
  );

  // Clock: DUT acts on falling edges; bench drives and samples on rising edges.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] model_rotr(input logic [WIDTH-1:0] d, input int n);
    logic [2*WIDTH-1:0] t;
    t = {d, d} >> n;
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] model_rotl1(input logic [WIDTH-1:0] d);
    logic [2*WIDTH-1:0] t;
    t = {d, d} << 1;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Driver: one operation, returns what was observed. Latency counts edges after acceptance.
  task automatic run_op(input logic [WIDTH-1:0] d, input int n, input int stall_at,
                        input int stall_len, input bit poke,
                        output int lat, output int busy_cnt, output logic [WIDTH-1:0] q_fin,
                        output logic [SHAMT_W-1:0] rem_fin, output logic busy_fin,
                        output logic done_after);
    @(posedge clock);
    D = d; amount = n[SHAMT_W-1:0]; start = 1'b1; enable = 1'b1;
    @(posedge clock);
    start = 1'b0; D = rand_word(); amount = SHAMT_W'($urandom_range(0, 127));
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 400) begin
      if (busy === 1'b1) busy_cnt++;
      enable = !(lat >= stall_at && lat < stall_at + stall_len);
      start  = poke && (lat == 2);
      if (start) D = '0;
      @(posedge clock);
      lat++;
    end
    start = 1'b0; enable = 1'b1;
    q_fin = Q; rem_fin = remaining; busy_fin = busy;
    @(posedge clock);
    done_after = done;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (Q !== '0) begin errors++; $display("FAIL reset_q got=%h exp=0", Q); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b exp=0,0", busy, done); end
    checks++; if (remaining !== '0) begin errors++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    @(posedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    int done_seen;
    @(posedge clock);
    D = '1; amount = 7'd100; start = 1'b1; enable = 1'b1;
    @(posedge clock);
    start = 1'b0;
    repeat (10) @(posedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before got=%b exp=1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (Q !== '0) begin errors++; $display("FAIL midop_reset_q got=%h exp=0", Q); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midop_reset_flags busy=%b done=%b exp=0,0", busy, done); end
    checks++; if (remaining !== '0) begin errors++; $display("FAIL midop_reset_remaining got=%0d exp=0", remaining); end
    repeat (2) @(posedge clock);
    reset = 1'b1;
    done_seen = 0;
    repeat (120) begin
      @(posedge clock);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL midop_after_release activity_cycles=%0d exp=0", done_seen); end
    checks++; if (Q !== '0) begin errors++; $display("FAIL midop_after_release_q got=%h exp=0", Q); end
  endtask

  task automatic test_single_step();
    int lat, bc; logic [WIDTH-1:0] q; logic [SHAMT_W-1:0] r; logic bf, da;
    logic [WIDTH-1:0] d;
    d = 128'h1;
    run_op(d, 1, 0, 0, 1'b0, lat, bc, q, r, bf, da);
    checks++; if (q !== model_rotr(d, 1)) begin errors++; $display("FAIL single_q got=%h exp=%h", q, model_rotr(d, 1)); end
    checks++; if (lat != 1) begin errors++; $display("FAIL single_latency got=%0d exp=1", lat); end
    checks++; if (bc != 1) begin errors++; $display("FAIL single_busy_cycles got=%0d exp=1", bc); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL single_done_width got=%b exp=0", da); end
  endtask

  task automatic test_nibble();
    int lat, bc; logic [WIDTH-1:0] q; logic [SHAMT_W-1:0] r; logic bf, da;
    logic [WIDTH-1:0] d;
    d = 128'hF;
    run_op(d, 4, 0, 0, 1'b0, lat, bc, q, r, bf, da);
    checks++; if (q !== model_rotr(d, 4)) begin errors++; $display("FAIL nibble_q got=%h exp=%h", q, model_rotr(d, 4)); end
    checks++; if (lat != 4) begin errors++; $display("FAIL nibble_latency got=%0d exp=4", lat); end
    checks++; if (r !== '0 || bf !== 1'b0) begin errors++; $display("FAIL nibble_done_state rem=%0d busy=%b exp=0,0", r, bf); end
  endtask

  task automatic test_zero_and_max();
    int lat, bc; logic [WIDTH-1:0] q; logic [SHAMT_W-1:0] r; logic bf, da;
    logic [WIDTH-1:0] d;
    d = rand_word();
    run_op(d, 0, 0, 0, 1'b0, lat, bc, q, r, bf, da);
    checks++; if (q !== d) begin errors++; $display("FAIL zero_q got=%h exp=%h", q, d); end
    checks++; if (lat != 0) begin errors++; $display("FAIL zero_latency got=%0d exp=0", lat); end
    checks++; if (bc != 0 || bf !== 1'b0) begin errors++; $display("FAIL zero_busy cycles=%0d busy=%b exp=0,0", bc, bf); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL zero_done_width got=%b exp=0", da); end
    d = 128'h1;
    run_op(d, 127, 0, 0, 1'b0, lat, bc, q, r, bf, da);
    checks++; if (q !== model_rotl1(d)) begin errors++; $display("FAIL max_q got=%h exp=%h", q, model_rotl1(d)); end
    checks++; if (lat != 127) begin errors++; $display("FAIL max_latency got=%0d exp=127", lat); end
  endtask

  task automatic test_stall_and_ignored_start();
    int lat, bc; logic [WIDTH-1:0] q; logic [SHAMT_W-1:0] r; logic bf, da;
    logic [WIDTH-1:0] d;
    d = rand_word();
    run_op(d, 8, 3, 3, 1'b1, lat, bc, q, r, bf, da);
    checks++; if (lat != 11) begin errors++; $display("FAIL stall_latency got=%0d exp=11", lat); end
    checks++; if (q !== model_rotr(d, 8)) begin errors++; $display("FAIL stall_q got=%h exp=%h", q, model_rotr(d, 8)); end
    checks++; if (bc != 11) begin errors++; $display("FAIL stall_busy_cycles got=%0d exp=11", bc); end
    checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL stall_no_queued_start state=%0d busy=%b exp=IDLE,0", dbg_state, busy); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d1, d2, r1;
    int n;
    d1 = rand_word(); d2 = rand_word(); r1 = model_rotr(d1, 2);
    @(posedge clock);
    D = d1; amount = 7'd2; start = 1'b1; enable = 1'b1;
    @(posedge clock);
    D = d2; amount = 7'd3;
    repeat (2) @(posedge clock);
    checks++; if (done !== 1'b1 || Q !== r1) begin errors++; $display("FAIL b2b_first done=%b q=%h exp=1,%h", done, Q, r1); end
    @(posedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || Q !== r1) begin errors++; $display("FAIL b2b_ignored_in_done busy=%b done=%b q=%h exp=0,0,%h", busy, done, Q, r1); end
    @(posedge clock);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || remaining !== 7'd3 || Q !== d2) begin errors++; $display("FAIL b2b_second_accept busy=%b rem=%0d q=%h exp=1,3,%h", busy, remaining, Q, d2); end
    n = 0;
    while (done !== 1'b1 && n < 50) begin @(posedge clock); n++; end
    checks++; if (n != 3 || Q !== model_rotr(d2, 3)) begin errors++; $display("FAIL b2b_second_result lat=%0d q=%h exp=3,%h", n, Q, model_rotr(d2, 3)); end
  endtask

  task automatic test_random();
    int lat, bc, n; logic [WIDTH-1:0] q; logic [SHAMT_W-1:0] r; logic bf, da;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 20; i++) begin
      d = rand_word(); n = $urandom_range(0, 127);
      run_op(d, n, 0, 0, 1'b0, lat, bc, q, r, bf, da);
      checks++;
      if (q !== model_rotr(d, n) || lat != n)
        begin errors++; $display("FAIL random_op[%0d] n=%0d q=%h lat=%0d exp=%h,%0d", i, n, q, lat, model_rotr(d, n), n); end
    end
  endtask

  task automatic test_round_trip();
    int lat, bc; logic [WIDTH-1:0] q; logic [SHAMT_W-1:0] r; logic bf, da;
    logic [WIDTH-1:0] w;
    for (int i = 0; i < 1000; i++) begin
      w = rand_word();
      run_op(model_rotl1(w), 1, 0, 0, 1'b0, lat, bc, q, r, bf, da);
      checks++;
      if (q !== w) begin errors++; $display("FAIL round_trip[%0d] got=%h exp=%h", i, q, w); end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; enable = 1'b1; amount = '0; D = '0;
    test_reset();
    test_single_step();
    test_nibble();
    test_zero_and_max();
    test_stall_and_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
